memory_controller_input: RTL and testbench
==========================================

# memory_controller_input

Write-side controller for one crossbar port buffer. Accepts 4-word packets from the port's ingress link and writes them into the port's 1024-word memory as consecutive 4-word slots. Tracks how many complete packets are stored and raises `req` toward the read-side controller, which acknowledges each consumed packet with its `start` pulse. It is the producer end of the `req`/`start` handshake used by the output controller.

## Interface
Parameters:
- `DATA_W`, 8, memory word width
- `ADDR_W`, 10, memory address width (1024 words = 256 slots of 4)

Ports:
- `clk` input 1: single clock; all state changes on the rising edge
- `rst` input 1: asynchronous, active-low reset (0 = reset)
- `in_valid` input 1: ingress beat present
- `in_sop` input 1: beat is word 0 of a packet
- `in_data` input DATA_W: ingress word
- `rd_start` input 1: one-cycle pulse from the read controller, one per packet consumed
- `in_ready` output 1: beat accepted when `in_valid && in_ready`
- `wen` output 1: memory write enable (registered)
- `waddr` output ADDR_W: memory write address (registered)
- `wdata` output DATA_W: memory write data (registered)
- `req` output 1: at least one complete packet stored
- `full` output 1: all 256 slots hold complete packets
- `err` output 1: one-cycle protocol-error pulse

## Operation
- Reset values: `wen`=0, `waddr`=0, `wdata`=0, `req`=0, `full`=0, `err`=0, write pointer=0, `pkt_cnt`=0, state IDLE, `in_ready`=1.
- States: IDLE (expecting word 0), BODY (words 1-3, beat index in `beat[1:0]`).
- IDLE: `in_valid && in_sop && !full` -> write word 0 at `{slot,2'b00}`, beat=1, go BODY. `in_valid && !in_sop` -> beat dropped, `err` pulse, stay IDLE.
- BODY: `in_valid && !in_sop` -> write at `{slot,beat}`, beat+1; on beat 3 write: slot+1, `pkt_cnt`+1, go IDLE.
- BODY with `in_valid && in_sop`: abort partial packet, `err` pulse, treat beat as word 0 of the same slot (beat=1, stay BODY); partial words are overwritten, `pkt_cnt` unchanged.
- `in_ready` = (state==BODY) || !full; combinational from state and `pkt_cnt`.
- `pkt_cnt` is 9 bits (0..256). `req` = `pkt_cnt`!=0; `full` = `pkt_cnt`==256; both from registered count.
- `rd_start` with `pkt_cnt`>0 -> `pkt_cnt`-1. `rd_start` with `pkt_cnt`==0 -> ignored, `err` pulse.
- Packet completion and `rd_start` in the same cycle -> `pkt_cnt` unchanged.
- Slot pointer is 8 bits; wraps 255 -> 0 (address 1023 -> 0) with no special handling.
- `wen` is 0 in any cycle following a non-accepted or dropped beat.

## Timing
- Beat accepted at edge N -> `wen`/`waddr`/`wdata` valid during cycle N..N+1 (one register stage).
- 4th-beat accept edge also updates `pkt_cnt`; `req` rises in the same cycle `wen` presents word 3.
- Back-to-back packets: word 0 of the next packet accepted the cycle after word 3; 4 cycles/packet sustained.
- `full` deasserts one cycle after the `rd_start` edge; `in_ready` follows combinationally.
- Async reset mid-packet: all state cleared immediately, partial packet and stored count lost; first edge after release sees IDLE.

## Structure
- Shared package: `BURST_LEN`=4, `ADDR_W`, `DATA_W`, `SLOTS`=256, state encoding (IDLE, BODY); also used by `memory_controller_output`.
- One natural sub-module: `pkt_credit_counter` (9-bit up/down count with inc, dec, `req`, `full`, underflow `err`).

## Test plan
- Single packet A0..A3 with sop on A0 after reset -> `wen` at addresses 0,1,2,3 with A0..A3; `req` 0->1 with the address-3 write; `pkt_cnt`=1.
- 256 back-to-back packets, no `rd_start` -> `full`=1, `in_ready`=0 in IDLE; 257th sop beat not written; one `rd_start` -> `full`=0 next cycle, packet 257 written at addresses 0..3.
- sop at beat 2 of slot 5 -> `err` pulse; new packet written at 20..23; `pkt_cnt` increments once only.
- Packet completion coincident with `rd_start` while `pkt_cnt`=3 -> `pkt_cnt` stays 3; `rd_start` at `pkt_cnt`=0 -> `err`, count stays 0.
- Non-sop beat in IDLE -> no `wen`, `err` pulse, pointer unchanged.
- `rst` low after beat 1 of packet at slot 7 -> all outputs 0 immediately; after release next packet written at 0..3.

Source files
------------

// File: rtl/memory_controller_pkg.sv
// Shared constants and state encoding for the crossbar port-buffer controllers.
package memory_controller_pkg;

    localparam int unsigned BURST_LEN = 4;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned SLOTS     = 256;
    localparam int unsigned CNT_W     = 9;

    typedef enum logic {
        StIdle,
        StBody
    } wr_state_e;

endpackage

// File: rtl/memory_controller_input_pkt_credit_counter.sv
// Count of complete packets held in the buffer; up on completion, down on read start.
module pkt_credit_counter
    import memory_controller_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic req,
    output logic full,
    output logic underflow
);

    localparam logic [CNT_W-1:0] FullCnt = CNT_W'(SLOTS);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dec_ok;

    always_comb begin
        dec_ok    = dec && (cnt_q != '0);
        underflow = dec && (cnt_q == '0);
        cnt_d     = cnt_q;
        // A completion and a consumption in the same cycle cancel out.
        if (inc && !dec_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!inc && dec_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign req  = (cnt_q != '0);
    assign full = (cnt_q == FullCnt);

endmodule

// File: rtl/memory_controller_input.sv
// Write-side port-buffer controller: packs 4-word ingress packets into consecutive memory slots.
module memory_controller_input
    import memory_controller_pkg::*;
#(
    parameter int unsigned DATA_W = memory_controller_pkg::DATA_W,
    parameter int unsigned ADDR_W = memory_controller_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic [DATA_W-1:0] in_data,
    input  logic              rd_start,
    output logic              in_ready,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              req,
    output logic              full,
    output logic              err
);

    localparam int unsigned SLOT_W = ADDR_W - 2;

    wr_state_e         state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              wen_q, err_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              complete;
    logic              proto_err;
    logic              underflow;

    pkt_credit_counter u_credit (
        .clk       (clk),
        .rst       (rst),
        .inc       (complete),
        .dec       (rd_start),
        .req       (req),
        .full      (full),
        .underflow (underflow)
    );

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        slot_d    = slot_q;
        wr_en     = 1'b0;
        wr_addr   = waddr_q;
        complete  = 1'b0;
        proto_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (!in_sop) begin
                        proto_err = 1'b1;
                    end else if (!full) begin
                        wr_en   = 1'b1;
                        wr_addr = {slot_q, 2'b00};
                        beat_d  = 2'd1;
                        state_d = StBody;
                    end
                end
            end
            StBody: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (in_sop) begin
                        // Restart the same slot; stale partial words get overwritten.
                        proto_err = 1'b1;
                        wr_addr   = {slot_q, 2'b00};
                        beat_d    = 2'd1;
                    end else begin
                        wr_addr = {slot_q, beat_q};
                        beat_d  = beat_q + 2'd1;
                        if (beat_q == 2'd3) begin
                            complete = 1'b1;
                            slot_d   = slot_q + SLOT_W'(1);
                            state_d  = StIdle;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            beat_q  <= '0;
            slot_q  <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            slot_q  <= slot_d;
            wen_q   <= wr_en;
            err_q   <= proto_err || underflow;
            if (wr_en) begin
                waddr_q <= wr_addr;
                wdata_q <= in_data;
            end
        end
    end

    assign in_ready = (state_q == StBody) || !full;
    assign wen      = wen_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign err      = err_q;

endmodule

// File: tb/tb_memory_controller_input.sv
// Self-checking bench for memory_controller_input: vector table, corner sequences, random vs model.
module tb_memory_controller_input;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sop = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          rd_start = 1'b0;
    logic          in_ready, wen, req, full, err;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    memory_controller_input dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_sop   (in_sop),
        .in_data  (in_data),
        .rd_start (rd_start),
        .in_ready (in_ready),
        .wen      (wen),
        .waddr    (waddr),
        .wdata    (wdata),
        .req      (req),
        .full     (full),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: packet count, next slot, and position within the open packet.
    int            m_cnt, m_slot, m_beat, m_waddr;
    logic          m_wen, m_err;
    logic [DW-1:0] m_wdata;

    typedef struct packed {
        logic          v, s;
        logic [DW-1:0] d;
        logic          r;
        logic          wen;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          req, full, err;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_slot = 0; m_beat = 0; m_waddr = 0;
        m_wen = 1'b0; m_err = 1'b0; m_wdata = '0;
    endtask

    task automatic model_write(input int a, input logic [DW-1:0] d);
        m_wen = 1'b1; m_waddr = a; m_wdata = d;
    endtask

    task automatic model_edge(input logic v, input logic s, input logic [DW-1:0] d, input logic r);
        int done, dec;
        done = 0; dec = 0;
        m_wen = 1'b0; m_err = 1'b0;
        if (v) begin
            if (m_beat == 0) begin
                if (!s) m_err = 1'b1;
                else if (m_cnt < 256) begin
                    model_write(m_slot * 4, d);
                    m_beat = 1;
                end
            end else if (s) begin
                m_err = 1'b1;
                model_write(m_slot * 4, d);
                m_beat = 1;
            end else begin
                model_write(m_slot * 4 + m_beat, d);
                m_beat++;
                if (m_beat == 4) begin
                    m_beat = 0;
                    m_slot = (m_slot + 1) % 256;
                    done = 1;
                end
            end
        end
        if (r) begin
            if (m_cnt > 0) dec = 1;
            else m_err = 1'b1;
        end
        m_cnt = m_cnt + done - dec;
    endtask

    task automatic step(input logic v, input logic s, input logic [DW-1:0] d, input logic r);
        @(negedge clk);
        in_valid = v; in_sop = s; in_data = d; rd_start = r;
        #1 chk("in_ready", in_ready, (m_beat != 0) || (m_cnt != 256));
        @(posedge clk);
        model_edge(v, s, d, r);
        #1;
        chk("wen", wen, m_wen);
        chk("waddr", waddr, m_waddr[AW-1:0]);
        chk("wdata", wdata, m_wdata);
        chk("req", req, m_cnt != 0);
        chk("full", full, m_cnt == 256);
        chk("err", err, m_err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0; in_sop = 1'b0; in_data = '0; rd_start = 1'b0;
        model_reset();
        #1;
        chk("rst_outs", {wen, waddr, wdata, req, full, err}, '0);
        chk("rst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send_pkt(input int tag, input logic r_last);
        for (int b = 0; b < 4; b++) begin
            step(1'b1, b == 0, DW'(tag * 4 + b), r_last && (b == 3));
        end
    endtask

    task automatic add(input logic v, s, input logic [DW-1:0] d, input logic r,
                       input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic rq, f, e);
        vq.push_back('{v, s, d, r, w, a, wd, rq, f, e});
    endtask

    initial begin
        add(1, 1, 8'hA0, 0,  1, 10'd0, 8'hA0, 0, 0, 0);
        add(1, 0, 8'hA1, 0,  1, 10'd1, 8'hA1, 0, 0, 0);
        add(1, 0, 8'hA2, 0,  1, 10'd2, 8'hA2, 0, 0, 0);
        add(1, 0, 8'hA3, 0,  1, 10'd3, 8'hA3, 1, 0, 0);
        add(0, 0, 8'h00, 0,  0, 10'd3, 8'hA3, 1, 0, 0);
        add(1, 0, 8'h55, 0,  0, 10'd3, 8'hA3, 1, 0, 1);
        add(0, 0, 8'h00, 1,  0, 10'd3, 8'hA3, 0, 0, 0);
        add(0, 0, 8'h00, 1,  0, 10'd3, 8'hA3, 0, 0, 1);
        add(1, 1, 8'hB0, 0,  1, 10'd4, 8'hB0, 0, 0, 0);
        add(1, 0, 8'hB1, 0,  1, 10'd5, 8'hB1, 0, 0, 0);
        add(1, 1, 8'hC0, 0,  1, 10'd4, 8'hC0, 0, 0, 1);
        add(1, 0, 8'hC1, 0,  1, 10'd5, 8'hC1, 0, 0, 0);
        add(1, 0, 8'hC2, 1,  1, 10'd6, 8'hC2, 0, 0, 1);
        add(1, 0, 8'hC3, 0,  1, 10'd7, 8'hC3, 1, 0, 0);
        add(0, 0, 8'h00, 1,  0, 10'd7, 8'hC3, 0, 0, 0);

        model_reset();
        repeat (2) @(negedge clk);
        #1 chk("por_outs", {wen, waddr, wdata, req, full, err}, '0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vq[i]) begin
            step(vq[i].v, vq[i].s, vq[i].d, vq[i].r);
            chk($sformatf("vec%0d", i), {wen, waddr, wdata, req, full, err},
                {vq[i].wen, vq[i].waddr, vq[i].wdata, vq[i].req, vq[i].full, vq[i].err});
        end

        // Fill all 256 slots, then one consumption frees a slot that wraps to address 0.
        do_reset();
        for (int p = 0; p < 256; p++) send_pkt(p, 1'b0);
        chk("fill_full", full, 1'b1);
        chk("fill_ready", in_ready, 1'b0);
        step(1'b1, 1'b1, 8'hEE, 1'b0);
        chk("fill_blocked_wen", wen, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("fill_release", {full, in_ready}, 2'b01);
        send_pkt(8'h3C, 1'b0);
        chk("wrap_addr", waddr, 10'd3);
        chk("wrap_full", full, 1'b1);

        // Restart at beat 2 of slot 5.
        do_reset();
        for (int p = 0; p < 5; p++) send_pkt(p, 1'b0);
        step(1'b1, 1'b1, 8'h50, 1'b0);
        step(1'b1, 1'b0, 8'h51, 1'b0);
        step(1'b1, 1'b1, 8'h60, 1'b0);
        chk("abort_err", err, 1'b1);
        chk("abort_addr", waddr, 10'd20);
        for (int b = 1; b < 4; b++) step(1'b1, 1'b0, DW'(8'h60 + b), 1'b0);
        chk("abort_last", {waddr, wdata}, {10'd23, 8'h63});
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("abort_cnt5", req, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("abort_cnt6", req, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("underflow_err", {err, req}, 2'b10);

        // Completion coincident with consumption at count 3.
        do_reset();
        for (int p = 0; p < 3; p++) send_pkt(p, 1'b0);
        send_pkt(3, 1'b1);
        for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("coinc_cnt2", req, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("coinc_cnt3", req, 1'b0);

        // Asynchronous reset during packet at slot 7.
        do_reset();
        for (int p = 0; p < 7; p++) send_pkt(p, 1'b0);
        step(1'b1, 1'b1, 8'h70, 1'b0);
        chk("pre_rst_addr", waddr, 10'd28);
        #2 rst = 1'b0;
        in_valid = 1'b0; in_sop = 1'b0; rd_start = 1'b0;
        model_reset();
        #1 chk("async_rst", {wen, waddr, wdata, req, full, err}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b0, 8'h71, 1'b0);
        chk("post_rst_idle_err", {wen, err}, 2'b01);
        send_pkt(8'h20, 1'b0);
        chk("post_rst_pkt", {waddr, req}, {10'd3, 1'b1});

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                 DW'($urandom), $urandom_range(0, 5) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
